// File: rtl/fu_alu_pipe.sv
// Pipelined integer ALU functional unit with issue-tag passthrough, stall and flush.
// Optional signed/unsigned MIN/MAX opcodes are enabled by defining FU_ALU_MINMAX_EN.
module fu_alu_pipe #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic [3:0]       ALUControl,
  input  logic [XLEN-1:0]  ALUA,
  input  logic [XLEN-1:0]  ALUB,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             stall,
  input  logic             flush,
  output logic             ready,
  output logic             finish,
  output logic [XLEN-1:0]  res,
  output logic             zero,
  output logic             overflow,
  output logic [TAG_W-1:0] tag_out
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_MAXU = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_AP4  = 4'b1011,
    OP_BOUT = 4'b1100,
    OP_MIN  = 4'b1101,
    OP_MAX  = 4'b1110,
    OP_MINU = 4'b1111
  } alu_op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [XLEN-1:0]  s1_a_q, s1_a_d;
  logic [XLEN-1:0]  s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  assign ready = ~stall;

  // Flush beats stall and EN; stall freezes the stage and refuses new ops.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (!stall) begin
      s1_valid_d = EN;
      if (EN) begin
        s1_op_d  = ALUControl;
        s1_a_d   = ALUA;
        s1_b_d   = ALUB;
        s1_tag_d = tag_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  logic [XLEN-1:0] add_res, sub_res, alu_res;
  logic [XLEN:0]   sub_ext;
  logic [SHW-1:0]  shamt;
  logic            add_ovf, sub_ovf, slt, sltu, alu_ovf;

  // SLTU is the borrow out of the widened subtract; SLT corrects the sign with overflow.
  always_comb begin
    add_res = s1_a_q + s1_b_q;
    sub_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    sub_res = sub_ext[XLEN-1:0];
    sltu    = sub_ext[XLEN];
    shamt   = s1_b_q[SHW-1:0];
    add_ovf = (s1_a_q[XLEN-1] == s1_b_q[XLEN-1]) && (add_res[XLEN-1] != s1_a_q[XLEN-1]);
    sub_ovf = (s1_a_q[XLEN-1] != s1_b_q[XLEN-1]) && (sub_res[XLEN-1] != s1_a_q[XLEN-1]);
    slt     = sub_res[XLEN-1] ^ sub_ovf;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op_e'(s1_op_q))
      OP_ADD:  begin alu_res = add_res; alu_ovf = add_ovf; end
      OP_SUB:  begin alu_res = sub_res; alu_ovf = sub_ovf; end
      OP_AND:  alu_res = s1_a_q & s1_b_q;
      OP_OR:   alu_res = s1_a_q | s1_b_q;
      OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
      OP_SLL:  alu_res = s1_a_q << shamt;
      OP_SRL:  alu_res = s1_a_q >> shamt;
      OP_SLT:  alu_res = XLEN'(slt);
      OP_SLTU: alu_res = XLEN'(sltu);
      OP_SRA:  alu_res = $unsigned($signed(s1_a_q) >>> shamt);
      OP_AP4:  alu_res = s1_a_q + XLEN'(4);
      OP_BOUT: alu_res = s1_b_q;
`ifdef FU_ALU_MINMAX_EN
      OP_MIN:  alu_res = slt  ? s1_a_q : s1_b_q;
      OP_MAX:  alu_res = slt  ? s1_b_q : s1_a_q;
      OP_MINU: alu_res = sltu ? s1_a_q : s1_b_q;
      OP_MAXU: alu_res = sltu ? s1_b_q : s1_a_q;
`endif
      default: alu_res = '0;
    endcase
  end

  logic             fin_int;
  logic [XLEN-1:0]  res_int;
  logic             ovf_int;
  logic [TAG_W-1:0] tag_int;

  generate
    if (LATENCY == 1) begin : g_direct
      assign fin_int = s1_valid_q;
      assign res_int = alu_res;
      assign ovf_int = alu_ovf;
      assign tag_int = s1_tag_q;
    end else begin : g_pipe
      logic [LATENCY-2:0] v_q, v_d;
      logic [LATENCY-2:0] o_q, o_d;
      logic [XLEN-1:0]    r_q [LATENCY-1];
      logic [XLEN-1:0]    r_d [LATENCY-1];
      logic [TAG_W-1:0]   t_q [LATENCY-1];
      logic [TAG_W-1:0]   t_d [LATENCY-1];

      always_comb begin
        v_d = v_q;
        o_d = o_q;
        r_d = r_q;
        t_d = t_q;
        if (flush) begin
          v_d = '0;
        end else if (!stall) begin
          v_d[0] = s1_valid_q;
          o_d[0] = alu_ovf;
          r_d[0] = alu_res;
          t_d[0] = s1_tag_q;
          for (int k = 1; k < LATENCY - 1; k++) begin
            v_d[k] = v_q[k-1];
            o_d[k] = o_q[k-1];
            r_d[k] = r_q[k-1];
            t_d[k] = t_q[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= '0;
          o_q <= '0;
          for (int k = 0; k < LATENCY - 1; k++) begin
            r_q[k] <= '0;
            t_q[k] <= '0;
          end
        end else begin
          v_q <= v_d;
          o_q <= o_d;
          r_q <= r_d;
          t_q <= t_d;
        end
      end

      assign fin_int = v_q[LATENCY-2];
      assign res_int = r_q[LATENCY-2];
      assign ovf_int = o_q[LATENCY-2];
      assign tag_int = t_q[LATENCY-2];
    end
  endgenerate

  assign finish   = fin_int;
  assign res      = fin_int ? res_int : '0;
  assign overflow = fin_int & ovf_int;
  assign tag_out  = fin_int ? tag_int : '0;
  assign zero     = fin_int && (res == '0);

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Directed self-checking bench for fu_alu_pipe: four instances covering
// LATENCY 1/2/3 at XLEN=32 and LATENCY 1 at XLEN=16 (default build, no MIN/MAX).
module tb_fu_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [4:0]  tag;

  logic        en1, st1, fl1, rdy1, fin1, z1, ov1;
  logic [31:0] res1;
  logic [4:0]  tg1;
  logic        en2, st2, fl2, rdy2, fin2, z2, ov2;
  logic [31:0] res2;
  logic [4:0]  tg2;
  logic        en3, st3, fl3, rdy3, fin3, z3, ov3;
  logic [31:0] res3;
  logic [4:0]  tg3;
  logic        en16, st16, fl16, rdy16, fin16, z16, ov16;
  logic [15:0] res16;
  logic [4:0]  tg16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fu_alu_pipe #(.XLEN(32), .LATENCY(1), .TAG_W(5)) u_lat1 (
    .clk(clk), .rst(rst), .EN(en1), .ALUControl(op), .ALUA(a), .ALUB(b), .tag_in(tag),
    .stall(st1), .flush(fl1), .ready(rdy1), .finish(fin1), .res(res1), .zero(z1),
    .overflow(ov1), .tag_out(tg1));

  fu_alu_pipe #(.XLEN(32), .LATENCY(2), .TAG_W(5)) u_lat2 (
    .clk(clk), .rst(rst), .EN(en2), .ALUControl(op), .ALUA(a), .ALUB(b), .tag_in(tag),
    .stall(st2), .flush(fl2), .ready(rdy2), .finish(fin2), .res(res2), .zero(z2),
    .overflow(ov2), .tag_out(tg2));

  fu_alu_pipe #(.XLEN(32), .LATENCY(3), .TAG_W(5)) u_lat3 (
    .clk(clk), .rst(rst), .EN(en3), .ALUControl(op), .ALUA(a), .ALUB(b), .tag_in(tag),
    .stall(st3), .flush(fl3), .ready(rdy3), .finish(fin3), .res(res3), .zero(z3),
    .overflow(ov3), .tag_out(tg3));

  fu_alu_pipe #(.XLEN(16), .LATENCY(1), .TAG_W(5)) u_x16 (
    .clk(clk), .rst(rst), .EN(en16), .ALUControl(op), .ALUA(a[15:0]), .ALUB(b[15:0]),
    .tag_in(tag), .stall(st16), .flush(fl16), .ready(rdy16), .finish(fin16), .res(res16),
    .zero(z16), .overflow(ov16), .tag_out(tg16));

  // op, A, B, expected res, expected overflow, expected zero (LATENCY=1, XLEN=32)
  localparam int NV = 16;
  localparam logic [3:0]  V_OP [NV] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h8, 4'h9,
                                        4'h2, 4'hB, 4'hC, 4'h1, 4'hD, 4'h0, 4'hA, 4'h1};
  localparam logic [31:0] V_A [NV] = '{32'hFF00FF00, 32'hF0000000, 32'hAAAAAAAA, 32'h00000001,
                                       32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                       32'h80000000, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF,
                                       32'hFFFFFFFF, 32'h00000005, 32'h7FFFFFF0, 32'h80000000};
  localparam logic [31:0] V_B [NV] = '{32'h0FF00FF0, 32'h0000000F, 32'hFFFFFFFF, 32'h0000003F,
                                       32'h0000003F, 32'h00000001, 32'h80000000, 32'h00000001,
                                       32'h00000001, 32'h00000000, 32'h12345678, 32'h00000001,
                                       32'h00000001, 32'h00000003, 32'h00000004, 32'h80000000};
  localparam logic [31:0] V_R [NV] = '{32'h0F000F00, 32'hF000000F, 32'h55555555, 32'h80000000,
                                       32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000,
                                       32'h7FFFFFFF, 32'h00000002, 32'h12345678, 32'h00000000,
                                       32'h00000000, 32'h00000000, 32'h07FFFFFF, 32'h00000000};
  localparam logic        V_O [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic        V_Z [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] va,
                               input logic [31:0] vb, input logic [4:0] t);
    op  = o;
    a   = va;
    b   = vb;
    tag = t;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
  endtask

  initial begin
    rst = 1'b1;
    {en1, st1, fl1, en2, st2, fl2, en3, st3, fl3, en16, st16, fl16} = '0;
    applyStimulus(4'h0, 32'h0, 32'h0, 5'd0);
    st2 = 1'b1;
    tick();
    tick();
    checkOutput("rst_finish", 32'(fin1), 32'd0);
    checkOutput("rst_res", res1, 32'd0);
    checkOutput("rst_zero", 32'(z1), 32'd0);
    checkOutput("rst_ovf", 32'(ov1), 32'd0);
    checkOutput("rst_tag", 32'(tg1), 32'd0);
    checkOutput("rst_ready", 32'(rdy1), 32'd1);
    checkOutput("rst_ready_stalled", 32'(rdy2), 32'd0);
    checkOutput("rst_finish_l3", 32'(fin3), 32'd0);
    st2 = 1'b0;
    rst = 1'b0;
    tick();

    $display("[TB] LATENCY=1 ADD overflow");
    applyStimulus(4'h1, 32'h7FFFFFFF, 32'h1, 5'd3);
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
    checkOutput("l1_add_finish", 32'(fin1), 32'd1);
    checkOutput("l1_add_res", res1, 32'h80000000);
    checkOutput("l1_add_ovf", 32'(ov1), 32'd1);
    checkOutput("l1_add_zero", 32'(z1), 32'd0);
    checkOutput("l1_add_tag", 32'(tg1), 32'd3);
    tick();
    checkOutput("l1_idle_finish", 32'(fin1), 32'd0);
    checkOutput("l1_idle_res_gated", res1, 32'd0);
    checkOutput("l1_idle_tag_gated", 32'(tg1), 32'd0);

    $display("[TB] LATENCY=1 opcode table");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(V_OP[i], V_A[i], V_B[i], 5'(i + 1));
      en1 = 1'b1;
      tick();
      checkOutput($sformatf("vec%0d_finish", i), 32'(fin1), 32'd1);
      checkOutput($sformatf("vec%0d_res", i), res1, V_R[i]);
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ov1), 32'(V_O[i]));
      checkOutput($sformatf("vec%0d_zero", i), 32'(z1), 32'(V_Z[i]));
      checkOutput($sformatf("vec%0d_tag", i), 32'(tg1), 32'(i + 1));
    end
    en1 = 1'b0;
    tick();

    $display("[TB] LATENCY=3 back-to-back");
    applyStimulus(4'h2, 32'd5, 32'd5, 5'd1);
    en3 = 1'b1;
    tick();
    checkOutput("l3_edge1_finish", 32'(fin3), 32'd0);
    applyStimulus(4'h9, 32'd1, 32'hFFFFFFFF, 5'd2);
    tick();
    checkOutput("l3_edge2_finish", 32'(fin3), 32'd0);
    applyStimulus(4'hA, 32'h80000000, 32'd4, 5'd3);
    tick();
    en3 = 1'b0;
    checkOutput("l3_r1_finish", 32'(fin3), 32'd1);
    checkOutput("l3_r1_res", res3, 32'd0);
    checkOutput("l3_r1_zero", 32'(z3), 32'd1);
    checkOutput("l3_r1_tag", 32'(tg3), 32'd1);
    tick();
    checkOutput("l3_r2_finish", 32'(fin3), 32'd1);
    checkOutput("l3_r2_res", res3, 32'd1);
    checkOutput("l3_r2_zero", 32'(z3), 32'd0);
    checkOutput("l3_r2_tag", 32'(tg3), 32'd2);
    tick();
    checkOutput("l3_r3_finish", 32'(fin3), 32'd1);
    checkOutput("l3_r3_res", res3, 32'hF8000000);
    checkOutput("l3_r3_tag", 32'(tg3), 32'd3);
    tick();
    checkOutput("l3_drain_finish", 32'(fin3), 32'd0);

    $display("[TB] LATENCY=2 stall hold");
    applyStimulus(4'h5, 32'h0000F0F0, 32'h00000FF0, 5'd7);
    en2 = 1'b1;
    tick();
    en2 = 1'b0;
    checkOutput("l2_edge1_finish", 32'(fin2), 32'd0);
    tick();
    checkOutput("l2_ontime_finish", 32'(fin2), 32'd1);
    checkOutput("l2_ontime_res", res2, 32'h0000FF00);
    st2 = 1'b1;
    en2 = 1'b1;
    applyStimulus(4'h1, 32'd1, 32'd1, 5'd9);
    #1;
    checkOutput("l2_stall_ready", 32'(rdy2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("l2_stall%0d_finish", i), 32'(fin2), 32'd1);
      checkOutput($sformatf("l2_stall%0d_res", i), res2, 32'h0000FF00);
      checkOutput($sformatf("l2_stall%0d_tag", i), 32'(tg2), 32'd7);
    end
    st2 = 1'b0;
    en2 = 1'b0;
    #1;
    checkOutput("l2_consume_finish", 32'(fin2), 32'd1);
    tick();
    checkOutput("l2_after_consume_finish", 32'(fin2), 32'd0);
    tick();
    checkOutput("l2_no_ghost_finish", 32'(fin2), 32'd0);

    $display("[TB] LATENCY=3 flush");
    en3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'h1, 32'(i), 32'd1, 5'(4 + i));
      tick();
    end
    checkOutput("l3_preflush_finish", 32'(fin3), 32'd1);
    fl3 = 1'b1;
    applyStimulus(4'h1, 32'd2, 32'd2, 5'd8);
    tick();
    fl3 = 1'b0;
    en3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("l3_flush%0d_finish", i), 32'(fin3), 32'd0);
      tick();
    end
    applyStimulus(4'h4, 32'h000000F0, 32'h00000F00, 5'd10);
    en3 = 1'b1;
    tick();
    en3 = 1'b0;
    tick();
    checkOutput("l3_post_edge2_finish", 32'(fin3), 32'd0);
    tick();
    checkOutput("l3_post_finish", 32'(fin3), 32'd1);
    checkOutput("l3_post_res", res3, 32'h00000FF0);
    checkOutput("l3_post_tag", 32'(tg3), 32'd10);

    $display("[TB] XLEN=16");
    en16 = 1'b1;
    applyStimulus(4'h6, 32'h0001, 32'h0013, 5'd2);
    tick();
    checkOutput("x16_sll_res", 32'(res16), 32'h0008);
    checkOutput("x16_sll_finish", 32'(fin16), 32'd1);
    applyStimulus(4'h8, 32'h8000, 32'h0001, 5'd4);
    tick();
    checkOutput("x16_slt_res", 32'(res16), 32'd1);
    checkOutput("x16_slt_tag", 32'(tg16), 32'd4);
    applyStimulus(4'h2, 32'h8000, 32'h0001, 5'd5);
    tick();
    checkOutput("x16_sub_res", 32'(res16), 32'h7FFF);
    checkOutput("x16_sub_ovf", 32'(ov16), 32'd1);
    applyStimulus(4'hA, 32'h8000, 32'h0011, 5'd6);
    tick();
    checkOutput("x16_sra_res", 32'(res16), 32'hC000);
    en16 = 1'b0;
    tick();
    checkOutput("x16_idle_finish", 32'(fin16), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
